seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Captures an unsigned binary value and shows it on a multiplexed 7-segment
// display. Decimal values go through a serial double-dabble conversion;
// hex values are committed directly. All digit registers and the overflow
// flag are committed together, so the scan never shows a half-converted
// value. The scan runs continuously, independent of the conversion.
module seg_display_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [DATA_W-1:0] Data_input,
    input  logic              Hex_mode,
    output logic              Busy,
    output logic              Overflow,
    output logic [6:0]        Segs,
    output logic [DIGITS-1:0] Digit_select
);

    // BCD nibbles needed to hold any DATA_W-bit value
    localparam int NIB    = (DATA_W + 2) / 3;
    localparam int BCD_W  = 4 * NIB;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HPAD_W = 4 * DIGITS + DATA_W;
    localparam int BPAD_W = 4 * DIGITS + BCD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [DATA_W-1:0]        bin_r;
    logic [BCD_W-1:0]         bcd_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     hex_r;
    logic                     busy_r;
    logic                     ovf_r;
    logic [DIGITS-1:0][3:0]   digit_r;
    logic [REF_W-1:0]         refresh_r;
    logic [SCAN_W-1:0]        scan_r;
    logic [6:0]               segs_r;
    logic [DIGITS-1:0]        sel_r;

    logic [HPAD_W-1:0]        hex_pad_s;
    logic [BPAD_W-1:0]        bcd_pad_s;
    logic [DIGITS-1:0][3:0]   new_digit_s;
    logic                     new_ovf_s;
    logic [DIGITS-1:0]        blank_s;
    logic                     seen_nz_s;
    logic [6:0]               seg_s;
    logic [DIGITS-1:0]        sel_s;

    // Add 3 to every BCD nibble that is 5 or more (double-dabble correction)
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < NIB; k++) begin
            if (b[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = b[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyph for a hex nibble
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Conversion FSM next-state; Load is only looked at in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Load) begin
                    state_s = Hex_mode ? DONE : SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state and Busy flag (Busy is high whenever the next state is not IDLE)
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Capture of the request and serial double-dabble shifting
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
            hex_r <= 1'b0;
        end else if (state_r == IDLE && Load) begin
            bin_r <= Data_input;
            bcd_r <= '0;
            cnt_r <= CNT_W'(DATA_W);
            hex_r <= Hex_mode;
        end else if (state_r == SHIFT) begin
            {bcd_r, bin_r} <= {dabble_adjust(bcd_r), bin_r} << 1;
            cnt_r          <= cnt_r - CNT_W'(1);
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
            hex_r <= hex_r;
        end
    end

    // Digits and overflow that DONE will commit; padding gives zeros above the source width
    always_comb begin
        hex_pad_s   = {{(4*DIGITS){1'b0}}, bin_r};
        bcd_pad_s   = {{(4*DIGITS){1'b0}}, bcd_r};
        new_digit_s = '0;
        new_ovf_s   = 1'b0;
        if (hex_r) begin
            for (int i = 0; i < DIGITS; i++) begin
                new_digit_s[i] = hex_pad_s[4*i +: 4];
            end
            new_ovf_s = |(hex_pad_s >> (4 * DIGITS));
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                new_digit_s[i] = bcd_pad_s[4*i +: 4];
            end
            new_ovf_s = |(bcd_pad_s >> (4 * DIGITS));
        end
    end

    // Atomic commit of all digits and the overflow flag in DONE
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            digit_r <= '0;
            ovf_r   <= 1'b0;
        end else if (state_r == DONE) begin
            digit_r <= new_digit_s;
            ovf_r   <= new_ovf_s;
        end else begin
            digit_r <= digit_r;
            ovf_r   <= ovf_r;
        end
    end

    // Leading-zero mask: a digit is blank if it and every digit above it is zero (digit 0 never blank)
    always_comb begin
        seen_nz_s = 1'b0;
        blank_s   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digit_r[i] != 4'd0) begin
                seen_nz_s = 1'b1;
            end else begin
                seen_nz_s = seen_nz_s;
            end
            if (BLANK_LZ != 0 && !ovf_r && !seen_nz_s) begin
                blank_s[i] = 1'b1;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    // Refresh divider and scan index, free-running
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            refresh_r <= '0;
            scan_r    <= '0;
        end else if (refresh_r == REF_W'(REFRESH_DIV - 1)) begin
            refresh_r <= '0;
            if (scan_r == SCAN_W'(DIGITS - 1)) begin
                scan_r <= '0;
            end else begin
                scan_r <= scan_r + SCAN_W'(1);
            end
        end else begin
            refresh_r <= refresh_r + REF_W'(1);
            scan_r    <= scan_r;
        end
    end

    // Glyph and digit enable for the currently scanned digit
    always_comb begin
        seg_s = 7'b1111111;
        sel_s = ~(DIGITS'(1) << scan_r);
        if (ovf_r) begin
            seg_s = 7'b0111111;
        end else if (blank_s[scan_r]) begin
            seg_s = 7'b1111111;
        end else begin
            seg_s = glyph(digit_r[scan_r]);
        end
    end

    // Segment and digit-select outputs registered together
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            segs_r <= 7'b1000000;
            sel_r  <= ~(DIGITS'(1));
        end else begin
            segs_r <= seg_s;
            sel_r  <= sel_s;
        end
    end

    assign Busy         = busy_r;
    assign Overflow     = ovf_r;
    assign Segs         = segs_r;
    assign Digit_select = sel_r;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: three instances share stimulus
// (A: 3 digits with blanking, B: 3 digits without, C: 2 digits with).
module tb_seg_display_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Load;
    logic [7:0] Data_input;
    logic       Hex_mode;

    logic       busy_a, busy_b, busy_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic [6:0] segs_a, segs_b, segs_c;
    logic [2:0] sel_a, sel_b;
    logic [1:0] sel_c;

    int total = 0;
    int bad   = 0;

    logic [6:0] sa [3];
    logic [6:0] sb [3];
    logic [6:0] sc [2];

    int n;

    seg_display_ctrl #(.DATA_W(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(1)) u_a (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Data_input(Data_input), .Hex_mode(Hex_mode),
        .Busy(busy_a), .Overflow(ovf_a), .Segs(segs_a), .Digit_select(sel_a));

    seg_display_ctrl #(.DATA_W(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(0)) u_b (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Data_input(Data_input), .Hex_mode(Hex_mode),
        .Busy(busy_b), .Overflow(ovf_b), .Segs(segs_b), .Digit_select(sel_b));

    seg_display_ctrl #(.DATA_W(8), .DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(1)) u_c (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Data_input(Data_input), .Hex_mode(Hex_mode),
        .Busy(busy_c), .Overflow(ovf_c), .Segs(segs_c), .Digit_select(sel_c));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one Load; optionally pulse a second Load on busy cycle inj_at; return busy length of A
    task automatic do_load(input logic [7:0] d, input logic h, input int inj_at,
                           input logic [7:0] inj_d, output int cnt);
        @(negedge Clk);
        Load = 1'b1; Data_input = d; Hex_mode = h;
        @(negedge Clk);
        Load = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!busy_a) break;
            cnt++;
            if (c == inj_at) begin
                Load = 1'b1; Data_input = inj_d; Hex_mode = 1'b0;
            end else begin
                Load = 1'b0;
            end
            @(negedge Clk);
        end
        Load = 1'b0;
    endtask

    // Record the glyph seen on each digit over more than one full scan
    task automatic scan_all();
        logic [2:0] one3;
        logic [1:0] one2;
        repeat (2) @(negedge Clk);
        for (int k = 0; k < 3; k++) begin sa[k] = 'x; sb[k] = 'x; end
        for (int k = 0; k < 2; k++) sc[k] = 'x;
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 3; k++) begin
                one3 = 3'b001 << k;
                if (sel_a == ~one3) sa[k] = segs_a;
                if (sel_b == ~one3) sb[k] = segs_b;
            end
            for (int k = 0; k < 2; k++) begin
                one2 = 2'b01 << k;
                if (sel_c == ~one2) sc[k] = segs_c;
            end
            @(negedge Clk);
        end
    endtask

    initial begin
        Reset = 1'b0; Load = 1'b0; Data_input = 8'd0; Hex_mode = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_ovf", 16'(ovf_a), 16'd0);
        check("rst_segs", 16'(segs_a), 16'h40);
        check("rst_sel_a", 16'(sel_a), 16'h6);
        check("rst_sel_c", 16'(sel_c), 16'h2);

        // refresh slot length
        Reset = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (sel_a == 3'b101) break;
            @(negedge Clk);
        end
        n = 0;
        for (int t = 0; t < 20; t++) begin
            if (sel_a != 3'b101) break;
            n++;
            @(negedge Clk);
        end
        check("slot_len", 16'(n), 16'd4);

        // 255 decimal
        do_load(8'd255, 1'b0, 0, 8'd0, n);
        check("busy_dec255", 16'(n), 16'd9);
        scan_all();
        check("d255_dig0", 16'(sa[0]), 16'h12);
        check("d255_dig1", 16'(sa[1]), 16'h12);
        check("d255_dig2", 16'(sa[2]), 16'h24);
        check("d255_ovf_a", 16'(ovf_a), 16'd0);
        check("d255_ovf_c", 16'(ovf_c), 16'd1);
        check("d255_c_dig1", 16'(sc[1]), 16'h3F);

        // A7 hex
        do_load(8'hA7, 1'b1, 0, 8'd0, n);
        check("busy_hex", 16'(n), 16'd1);
        scan_all();
        check("hA7_dig0", 16'(sa[0]), 16'h78);
        check("hA7_dig1", 16'(sa[1]), 16'h08);
        check("hA7_dig2", 16'(sa[2]), 16'h7F);
        check("hA7_b_dig2", 16'(sb[2]), 16'h40);
        check("hA7_ovf_c", 16'(ovf_c), 16'd0);

        // 7 decimal, blanking on/off
        do_load(8'd7, 1'b0, 0, 8'd0, n);
        scan_all();
        check("d7_a_dig0", 16'(sa[0]), 16'h78);
        check("d7_a_dig1", 16'(sa[1]), 16'h7F);
        check("d7_a_dig2", 16'(sa[2]), 16'h7F);
        check("d7_b_dig1", 16'(sb[1]), 16'h40);
        check("d7_b_dig2", 16'(sb[2]), 16'h40);

        // 100 decimal: overflows 2 digits
        do_load(8'd100, 1'b0, 0, 8'd0, n);
        scan_all();
        check("d100_ovf_c", 16'(ovf_c), 16'd1);
        check("d100_c_dig0", 16'(sc[0]), 16'h3F);
        check("d100_c_dig1", 16'(sc[1]), 16'h3F);
        check("d100_a_dig0", 16'(sa[0]), 16'h40);
        check("d100_a_dig2", 16'(sa[2]), 16'h79);

        // 99 decimal: fits 2 digits
        do_load(8'd99, 1'b0, 0, 8'd0, n);
        scan_all();
        check("d99_ovf_c", 16'(ovf_c), 16'd0);
        check("d99_c_dig0", 16'(sc[0]), 16'h10);
        check("d99_c_dig1", 16'(sc[1]), 16'h10);
        check("d99_a_dig2", 16'(sa[2]), 16'h7F);

        // 200 with a second Load of 50 while busy
        do_load(8'd200, 1'b0, 3, 8'd50, n);
        check("busy_ignored", 16'(n), 16'd9);
        scan_all();
        check("d200_dig0", 16'(sa[0]), 16'h40);
        check("d200_dig1", 16'(sa[1]), 16'h40);
        check("d200_dig2", 16'(sa[2]), 16'h24);
        check("d200_ovf_c", 16'(ovf_c), 16'd1);

        // reset in the middle of a conversion
        @(negedge Clk);
        Load = 1'b1; Data_input = 8'd123; Hex_mode = 1'b0;
        @(negedge Clk);
        Load = 1'b0;
        repeat (3) @(negedge Clk);
        check("mid_busy_pre", 16'(busy_a), 16'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("mid_rst_busy", 16'(busy_a), 16'd0);
        check("mid_rst_segs", 16'(segs_a), 16'h40);
        check("mid_rst_sel", 16'(sel_a), 16'h6);
        check("mid_rst_ovf_c", 16'(ovf_c), 16'd0);
        @(negedge Clk);
        Reset = 1'b1;
        scan_all();
        check("post_rst_busy", 16'(busy_a), 16'd0);
        check("post_rst_dig0", 16'(sa[0]), 16'h40);
        check("post_rst_dig1", 16'(sa[1]), 16'h7F);
        check("post_rst_dig2", 16'(sa[2]), 16'h7F);
        check("post_rst_b_dig2", 16'(sb[2]), 16'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
